instr_prefetch_unit: RTL and testbench
======================================

Name: instr_prefetch_unit

Overview:
Instruction fetch front-end that sits directly upstream of the single-cycle datapath's decode/control.
- Reads the byte-wide instruction memory one byte per cycle.
- Assembles big-endian 32-bit words and queues them, with their PCs, in a small FIFO.
- Presents them to the consumer over a valid/ready handshake.
- Branch/jump redirect flushes the queue and restarts fetch at the target.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
MEM_AW, 5, instruction-memory byte address width (32 bytes)
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
mem_addr  output  MEM_AW  byte address to instruction memory
mem_rd  output  1  byte read strobe
mem_rdata  input  8  byte at mem_addr, valid combinationally in the same cycle
redirect  input  1  flush and restart fetch
redirect_pc  input  32  new fetch address
inst_valid  output  1  head entry valid
inst_ready  input  1  consumer accepts head entry
inst_data  output  32  head instruction word
inst_pc  output  32  PC of head instruction
fifo_count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
Clock and reset:
- Single clock `clk`; reset `rst` is synchronous and active-high.
- Reset (highest priority) sets: fetch_pc=RESET_PC, byte_idx=0, count=0, FIFO pointers=0, FIFO storage=0, partial word=0.
- Reset therefore drives inst_valid=0, inst_data=0, inst_pc=0, mem_rd=0, fifo_count=0.
- Reset mid-word discards the partial word.

Fetch sequencer (byte_idx 0..3):
- A word may start (byte_idx==0) only when count<DEPTH. Only one word is ever in flight, so overflow is impossible.
- While a word is in flight: mem_rd=1 and mem_addr=(fetch_pc[MEM_AW-1:0]+byte_idx) mod 2^MEM_AW.
- Big-endian assembly: byte0 -> [31:24], byte1 -> [23:16], byte2 -> [15:8], byte3 -> [7:0].
- At byte_idx==3: push {word, fetch_pc}, then fetch_pc += 4 (32-bit wrap) and byte_idx returns to 0.
- When count==DEPTH at byte_idx 0: mem_rd=0 and hold.

Output queue:
- inst_valid = (count!=0); inst_data and inst_pc are taken from the head entry.
- Pop when inst_valid && inst_ready.
- Push and pop in the same cycle leave count unchanged.
- Latency: the first word completed in cycle N is visible on the outputs in cycle N+1. After reset release, inst_valid first rises 5 cycles later.
- Steady state: one word per 4 cycles.

Redirect (priority below rst, above everything else):
- Effects: count=0, pointers=0, partial word discarded, byte_idx=0, fetch_pc={redirect_pc[31:2],2'b00}.
- Misaligned targets are silently aligned down.
- mem_rd=0 during the redirect cycle.
- A pop or push coinciding with redirect is discarded.
- In the next cycle inst_valid=0 and fetch begins at the new pc.

Optional Feature:
Macro PREFETCH_STATS_EN.
- Defined: adds outputs stat_words (32 bits, number of words pushed) and stat_flushes (16 bits, number of redirect cycles). Both counters are saturating, clear on rst, and redirect does not clear them.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Reset with mem[0..3]=8C,01,00,04 and inst_ready=0 -> cycle 5 after reset release: inst_valid=1, inst_data=8C010004, inst_pc=0, fifo_count=1.
2. inst_ready=0 for 30 cycles -> fifo_count saturates at 4 after 16 read cycles, then mem_rd=0. Draining afterwards yields inst_pc 0,4,8,C in order with the matching words.
3. Redirect to 0x16 after byte 2 of the word at 0x8 -> next cycle inst_valid=0, fifo_count=0, mem_addr=0x14. The next delivered word has inst_pc=0x14 and no stale entry appears.
4. Redirect to 0x1C -> mem_addr sequence 1C,1D,1E,1F, then 00 for the word with inst_pc=0x20 (address wrap).
5. inst_ready held at 1 -> one word every 4 cycles, fifo_count never exceeds 1. Pop and push in the same cycle keep the count steady.
6. rst asserted at byte_idx 2 of a word with 2 entries queued -> next cycle inst_valid=0, mem_rd=0, fifo_count=0. Fetch restarts at RESET_PC; with PREFETCH_STATS_EN defined, stat_words=0.

Source files
------------

// File: rtl/instr_prefetch_unit.sv
// Byte-serial instruction prefetcher: assembles big-endian words into a small FIFO with PCs.
// Optional PREFETCH_STATS_EN adds saturating word/flush counters.
module instr_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter int          MEM_AW   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic                    mem_rd,
  input  logic [7:0]              mem_rdata,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [31:0]             inst_data,
  output logic [31:0]             inst_pc,
  output logic [$clog2(DEPTH):0]  fifo_count
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]             stat_words,
  output logic [15:0]             stat_flushes
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [1:0]    byte_idx;
  logic [23:0]   word_acc;
  logic [PW:0]   count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic          fetch_active;
  logic          push;
  logic          pop;

  // A new word only starts with room in the queue; a word in flight always finishes.
  assign fetch_active = (byte_idx != 2'd0) || (count != FULL);
  assign mem_rd       = !rst && !redirect && fetch_active;
  assign mem_addr     = fetch_pc[MEM_AW-1:0] + MEM_AW'(byte_idx);
  assign push         = mem_rd && (byte_idx == 2'd3);
  assign inst_valid   = (count != '0);
  assign pop          = inst_valid && inst_ready && !redirect && !rst;
  assign inst_data    = q_data[rd_ptr];
  assign inst_pc      = q_pc[rd_ptr];
  assign fifo_count   = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      byte_idx <= 2'd0;
      word_acc <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      byte_idx <= 2'd0;
      word_acc <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (mem_rd) begin
        case (byte_idx)
          2'd0:    word_acc[23:16] <= mem_rdata;
          2'd1:    word_acc[15:8]  <= mem_rdata;
          2'd2:    word_acc[7:0]   <= mem_rdata;
          default: word_acc        <= '0;
        endcase
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3)
          fetch_pc <= fetch_pc + 32'd4;
      end
      // Final byte bypasses the accumulator straight into the queue.
      if (push) begin
        q_data[wr_ptr] <= {word_acc, mem_rdata};
        q_pc[wr_ptr]   <= fetch_pc;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef PREFETCH_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words   <= '0;
      stat_flushes <= '0;
    end else begin
      if (push)
        stat_words <= sat_inc32(stat_words);
      if (redirect)
        stat_flushes <= sat_inc16(stat_flushes);
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed plus randomized bench for instr_prefetch_unit with a transaction-level scoreboard.
module tb_instr_prefetch_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [2:0]  fifo_count;
`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_words;
  logic [15:0] stat_flushes;
`endif

  logic [7:0] mem [32];
  int checks = 0;
  int errors = 0;

  instr_prefetch_unit #(.DEPTH(4), .MEM_AW(5), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc), .fifo_count(fifo_count)
`ifdef PREFETCH_STATS_EN
    , .stat_words(stat_words), .stat_flushes(stat_flushes)
`endif
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Big-endian word at a byte address, with the 32-byte memory wrapping.
  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [31:0] w;
    logic [4:0]  a;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      a = pc[4:0] + 5'(k);
      w = {w[23:0], mem[a]};
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves the bench in cycle 1 after reset release.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst_valid", inst_valid, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_memrd", mem_rd, 0);
    chk("rst_count", fifo_count, 0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int pops;
    int maxcnt;

    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;

    // Test 1: first word latency
    do_reset();
    chk("t1_memrd_c1", mem_rd, 1);
    chk("t1_addr_c1", mem_addr, 0);
    ticks(3);
    chk("t1_valid_c4", inst_valid, 0);
    tick();
    chk("t1_valid_c5", inst_valid, 1);
    chk("t1_data", inst_data, 32'h8C01_0004);
    chk("t1_pc", inst_pc, 0);
    chk("t1_count", fifo_count, 1);

    // Test 2: fill to full, then drain in order
    ticks(12);
    chk("t2_count_c17", fifo_count, 4);
    chk("t2_memrd_c17", mem_rd, 0);
    ticks(13);
    chk("t2_count_c30", fifo_count, 4);
    chk("t2_memrd_c30", mem_rd, 0);
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_drain_valid", inst_valid, 1);
      chk("t2_drain_pc", inst_pc, 32'(4 * i));
      chk("t2_drain_data", inst_data, exp_word(32'(4 * i)));
      tick();
    end
    chk("t2_empty_valid", inst_valid, 0);
    chk("t2_empty_count", fifo_count, 0);
    tick();
    chk("t2_next_pc", inst_pc, 32'h10);
    chk("t2_next_data", inst_data, exp_word(32'h10));
    inst_ready = 1'b0;

    // Test 3: redirect to 0x16 while last byte of word 0x8 is read
    do_reset();
    ticks(11);
    chk("t3_addr_c12", mem_addr, 5'h0B);
    chk("t3_count_c12", fifo_count, 2);
    redirect = 1'b1; redirect_pc = 32'h16;
    #1;
    chk("t3_memrd_redir", mem_rd, 0);
    tick();
    redirect = 1'b0;
    #1;
    chk("t3_valid_after", inst_valid, 0);
    chk("t3_count_after", fifo_count, 0);
    chk("t3_addr_after", mem_addr, 5'h14);
    chk("t3_memrd_after", mem_rd, 1);
    inst_ready = 1'b1;
    ticks(4);
    chk("t3_valid_first", inst_valid, 1);
    chk("t3_pc_first", inst_pc, 32'h14);
    chk("t3_data_first", inst_data, exp_word(32'h14));
    ticks(4);
    chk("t3_pc_second", inst_pc, 32'h18);
    chk("t3_data_second", inst_data, exp_word(32'h18));

    // Test 4: misaligned redirect to 0x1D and address wrap
    redirect = 1'b1; redirect_pc = 32'h1D;
    tick();
    redirect = 1'b0;
    #1;
    chk("t4_valid_after", inst_valid, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t4_addr_seq", mem_addr, 32'(5'h1C + 5'(k)));
      tick();
    end
    chk("t4_addr_wrap", mem_addr, 0);
    chk("t4_pc_1c", inst_pc, 32'h1C);
    chk("t4_data_1c", inst_data, exp_word(32'h1C));
    ticks(4);
    chk("t4_pc_20", inst_pc, 32'h20);
    chk("t4_data_20", inst_data, 32'h8C01_0004);
    inst_ready = 1'b0;

    // Test 5: simultaneous push/pop, then streaming at one word per 4 cycles
    do_reset();
    ticks(7);
    chk("t5_count_c8", fifo_count, 1);
    inst_ready = 1'b1;
    tick();
    chk("t5_count_pushpop", fifo_count, 1);
    chk("t5_pc_c9", inst_pc, 32'h4);
    pops = 0; maxcnt = 0; exp_pc = 32'h4;
    for (int c = 0; c < 40; c++) begin
      if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
      if (inst_valid) begin
        chk("t5_stream_pc", inst_pc, exp_pc);
        exp_pc += 32'd4;
        pops++;
      end
      tick();
    end
    chk("t5_pops", pops, 10);
    chk("t5_maxcount", maxcnt, 1);
    inst_ready = 1'b0;

    // Test 6: reset mid-word with two entries queued
    do_reset();
    ticks(10);
    chk("t6_count_c11", fifo_count, 2);
    chk("t6_addr_c11", mem_addr, 5'h0A);
    rst = 1'b1;
    tick();
    chk("t6_valid", inst_valid, 0);
    chk("t6_memrd", mem_rd, 0);
    chk("t6_count", fifo_count, 0);
`ifdef PREFETCH_STATS_EN
    chk("t6_stat_words", stat_words, 0);
    chk("t6_stat_flushes", stat_flushes, 0);
`endif
    rst = 1'b0;
    #1;
    chk("t6_restart_rd", mem_rd, 1);
    chk("t6_restart_addr", mem_addr, 0);
    ticks(4);
    chk("t6_restart_pc", inst_pc, 0);
    chk("t6_restart_data", inst_data, 32'h8C01_0004);

    // Random phase: random backpressure and redirects against an in-order PC scoreboard
    exp_pc = 32'h0; pops = 0;
    for (int c = 0; c < 800; c++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 29) == 0);
      if (redirect) redirect_pc = $urandom;
      #1;
      chk("rnd_count_bound", (fifo_count <= 3'd4), 1);
      chk("rnd_valid_vs_count", inst_valid, (fifo_count != 3'd0));
      if (redirect) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (inst_valid && inst_ready) begin
        chk("rnd_pc", inst_pc, exp_pc);
        chk("rnd_data", inst_data, exp_word(exp_pc));
        exp_pc += 32'd4;
        pops++;
      end
      tick();
    end
    redirect = 1'b0;
    chk("rnd_progress", (pops > 50), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
